serial_subtractor_5b: RTL and testbench

Bit-serial ripple-borrow subtractor computing D = A − B − BIN over WIDTH clock cycles (one bit per cycle, LSB first), with a start/busy/done handshake. It is the inverse-operation counterpart of the combinational 5-bit ripple-carry full adder. It trades the adder's parallel ripple chain for a single full-subtractor cell plus shift registers. It sits as a standalone arithmetic unit and is driven by a controller or testbench that presents operands and waits for DONE.

---
 rtl/serial_subtractor_5b_if.sv | 27 ++
 rtl/serial_subtractor_5b.sv | 120 ++++++++++++
 tb/tb_serial_subtractor_5b.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_5b_if.sv
// Operand/result bundle for the bit-serial subtractor.
// Handshake: start is honoured only while the unit is idle (busy=0, done=0); operands are
// captured on that edge, busy stays high while bits are processed, and done pulses for one
// cycle when d/bout/ovf have just been updated.
interface serial_subtractor_5b_if #(
  parameter int WIDTH = 5
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, d, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, d, bout, ovf
  );
endinterface

// File: rtl/serial_subtractor_5b.sv
// Bit-serial ripple-borrow subtractor: D = A - B - BIN, one bit per cycle, LSB first.
// A single full-subtractor cell is reused WIDTH times between two shift registers.
module serial_subtractor_5b #(
  parameter int WIDTH = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  serial_subtractor_5b_if.slave bus,
  output logic [1:0]            o_dbg_state
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_d_sr;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;
  logic             r_a_msb;
  logic             r_b_msb;
  logic [WIDTH-1:0] r_d;
  logic             r_bout;
  logic             r_ovf;

  logic             w_busy;
  logic             w_done;
  logic             w_last;
  logic             w_a0;
  logic             w_b0;
  logic             w_diff;
  logic             w_borrow_next;
  logic [WIDTH-1:0] w_d_next;

  // Full-subtractor cell working on the current LSBs.
  assign w_a0          = r_a_sr[0];
  assign w_b0          = r_b_sr[0];
  assign w_diff        = w_a0 ^ w_b0 ^ r_borrow;
  assign w_borrow_next = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_borrow);
  assign w_d_next      = {w_diff, r_d_sr[WIDTH-1:1]};
  assign w_last        = (r_cnt == CW'(WIDTH - 1));

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = S_SHIFT;
      end
      S_SHIFT: begin
        w_busy = 1'b1;
        if (w_last) w_next = S_FINISH;
      end
      S_FINISH: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_d_sr   <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_d      <= '0;
      r_bout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a_sr   <= bus.a;
            r_b_sr   <= bus.b;
            r_borrow <= bus.bin;
            r_d_sr   <= '0;
            r_cnt    <= '0;
            r_a_msb  <= bus.a[WIDTH-1];
            r_b_msb  <= bus.b[WIDTH-1];
          end
        end
        S_SHIFT: begin
          r_d_sr   <= w_d_next;
          r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
          r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
          r_borrow <= w_borrow_next;
          r_cnt    <= r_cnt + CW'(1);
          // Visible results only move on the final bit, so they stay stable mid-operation.
          if (w_last) begin
            r_d    <= w_d_next;
            r_bout <= w_borrow_next;
            r_ovf  <= (r_a_msb != r_b_msb) && (w_diff != r_a_msb);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = w_busy;
  assign bus.done    = w_done;
  assign bus.d       = r_d;
  assign bus.bout    = r_bout;
  assign bus.ovf     = r_ovf;
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_serial_subtractor_5b.sv
// Self-checking bench for serial_subtractor_5b: directed cases, handshake, abort, ramp
// sweep and random operands, all against an arithmetic reference model.
module tb_serial_subtractor_5b;
  localparam int W = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W+1:0] exp_q[$];
  logic [W+1:0] last_res;

  always #5 clk = ~clk;

  serial_subtractor_5b_if #(.WIDTH(W)) bus ();

  serial_subtractor_5b #(.WIDTH(W)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  // Reference: {ovf, bout, d} from plain integer arithmetic on the operands.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic bin);
    int ua, ub, sa, sb, diff, sres;
    logic ovf, bout;
    logic [W-1:0] d;
    ua   = int'(a);
    ub   = int'(b);
    sa   = a[W-1] ? ua - (1 << W) : ua;
    sb   = b[W-1] ? ub - (1 << W) : ub;
    diff = ua - ub - int'(bin);
    bout = (diff < 0);
    d    = W'(diff + (1 << W));
    sres = sa - sb - int'(bin);
    ovf  = (sres < -(1 << (W - 1))) || (sres > (1 << (W - 1)) - 1);
    return {ovf, bout, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation from an idle unit, checking timing and results cycle by cycle.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       input string name);
    logic [W+1:0] exp;
    exp = model(a, b, bin);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.bin   = bin;
    for (int i = 0; i < W; i++) begin
      tick();
      if (i == 0) begin
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.bin   = 1'($urandom);
      end
      n_checks++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0 ||
          {bus.ovf, bus.bout, bus.d} !== last_res) begin
        n_fail++;
        $display("FAIL %s shift cycle %0d: busy=%b done=%b res=%b, required busy=1 done=0 res=%b",
                 name, i, bus.busy, bus.done, {bus.ovf, bus.bout, bus.d}, last_res);
      end
    end
    tick();
    n_checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || {bus.ovf, bus.bout, bus.d} !== exp) begin
      n_fail++;
      $display("FAIL %s result a=%b b=%b bin=%b: done=%b busy=%b {ovf,bout,d}=%b, required done=1 busy=0 %b",
               name, a, b, bin, bus.done, bus.busy, {bus.ovf, bus.bout, bus.d}, exp);
    end
    last_res = exp;
    tick();
    n_checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL %s return to idle: done=%b busy=%b state=%0d, required 0 0 0",
               name, bus.done, bus.busy, dbg_state);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.a     = 5'b10110;
    bus.b     = 5'b00101;
    bus.bin   = 1'b1;
    tick();
    tick();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.d !== '0 || bus.bout !== 1'b0 ||
        bus.ovf !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b d=%b bout=%b ovf=%b state=%0d, required all 0",
               bus.busy, bus.done, bus.d, bus.bout, bus.ovf, dbg_state);
    end
    bus.start = 1'b0;
    rst       = 1'b0;
    last_res  = '0;
    tick();
  endtask

  task automatic test_directed();
    do_op(5'b10110, 5'b00101, 1'b0, "basic");
    do_op(5'b00011, 5'b00101, 1'b1, "borrow_in_out");
    do_op(5'b01111, 5'b10000, 1'b0, "ovf_pos");
    do_op(5'b10000, 5'b00000, 1'b1, "ovf_bin");
    do_op(5'b00000, 5'b11111, 1'b1, "max_borrow");
    do_op(5'b11111, 5'b11111, 1'b0, "zero");
  endtask

  // START held high: only operands present on idle edges (every W+2 cycles) are used.
  task automatic test_back_to_back();
    logic [W+1:0] exp;
    int ph;
    bus.start = 1'b1;
    for (int c = 0; c < 3 * (W + 2); c++) begin
      ph      = c % (W + 2);
      bus.a   = W'($urandom);
      bus.b   = W'($urandom);
      bus.bin = 1'($urandom);
      if (ph == 0) exp_q.push_back(model(bus.a, bus.b, bus.bin));
      tick();
      n_checks++;
      if (ph == W) begin
        exp = exp_q.pop_front();
        if (bus.done !== 1'b1 || {bus.ovf, bus.bout, bus.d} !== exp) begin
          n_fail++;
          $display("FAIL b2b done cycle %0d: done=%b res=%b, required done=1 res=%b",
                   c, bus.done, {bus.ovf, bus.bout, bus.d}, exp);
        end
        last_res = exp;
      end else if (bus.done !== 1'b0 || bus.busy !== (ph < W) ||
                   {bus.ovf, bus.bout, bus.d} !== last_res) begin
        n_fail++;
        $display("FAIL b2b cycle %0d: done=%b busy=%b res=%b, required done=0 busy=%b res=%b",
                 c, bus.done, bus.busy, {bus.ovf, bus.bout, bus.d}, ph < W, last_res);
      end
    end
    bus.start = 1'b0;
    tick();
    n_checks++;
    if (dbg_state !== 2'd0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b end: state=%0d pending=%0d, required 0 0", dbg_state, exp_q.size());
    end
  endtask

  task automatic test_abort();
    do_op(5'b10110, 5'b00101, 1'b0, "pre_abort");
    bus.start = 1'b1;
    bus.a     = 5'b01111;
    bus.b     = 5'b10000;
    bus.bin   = 1'b0;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    last_res = '0;
    for (int i = 0; i < W + 3; i++) begin
      n_checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || {bus.ovf, bus.bout, bus.d} !== '0) begin
        n_fail++;
        $display("FAIL abort cycle %0d: done=%b busy=%b res=%b, required 0 0 0",
                 i, bus.done, bus.busy, {bus.ovf, bus.bout, bus.d});
      end
      tick();
    end
    do_op(5'b00011, 5'b00101, 1'b1, "post_abort");
  endtask

  task automatic test_sweep();
    logic [W-1:0] a, b;
    logic bin;
    a   = W'($urandom);
    b   = W'($urandom);
    bin = 1'b0;
    for (int i = 0; i < 32; i++) begin
      do_op(a, b, bin, "sweep");
      a   = a + W'(2);
      b   = b + W'(1);
      bin = ~bin;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++)
      do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), "random");
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    last_res  = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_abort();
    test_sweep();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
